md_unit: RTL and testbench
==========================

# md_unit

Parametrised multiply/divide unit for the E stage of the five-stage pipeline, owning the HI/LO register pair. It accepts one operation per start pulse, holds `busy` for a configurable number of cycles while the result is pending, and then commits the result to HI/LO. The hazard unit stalls the D stage on any HI/LO-dependent instruction while `start | busy` is high. The unit generalises the fixed 32-bit datapath to any operand width, with independent multiply and divide latencies.

## Interface
- `WIDTH`, default 32: operand width and HI/LO width.
- `MULT_CYCLES`, default 5: busy duration for multiply-class ops. Must be ≥1.
- `DIV_CYCLES`, default 10: busy duration for divide-class ops. Must be ≥1.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-low. When `reset==0` at an edge, all state clears.
- `start`, input, 1: launch `op` this cycle.
- `op`, input, 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB.
- `A`, input, WIDTH: rs operand, already forwarded.
- `B`, input, WIDTH: rt operand, already forwarded.
- `busy`, output, 1: an operation is in flight.
- `hi`, output, WIDTH: architectural HI.
- `lo`, output, WIDTH: architectural LO.

## Operation
- States: IDLE and RUN. A counter `cnt` of width ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)) tracks progress.
- At reset: state=IDLE, `cnt`=0, `busy`=0, `hi`=0, `lo`=0, and the pending result registers are 0.
- IDLE with `start=1`:
  - MULT, MULTU, DIV, DIVU, MADD, MSUB: compute the full result from A/B and latch it into pending registers (temp_hi, temp_lo). Load `cnt` with the op latency and go to RUN.
  - MTHI: `hi<=A`. MTLO: `lo<=A`. Both stay in IDLE with no busy cycle.
- RUN: `cnt` decrements each cycle. On the edge where `cnt==1`, `hi/lo <= temp_hi/temp_lo`, `busy<=0`, and state returns to IDLE.
- `start` during RUN is ignored, including MTHI/MTLO. The hazard unit guarantees this never happens in normal flow. The bench checks it is a no-op.
- Arithmetic rules:
  - MULT: signed WIDTH×WIDTH→2·WIDTH, giving {hi,lo}.
  - MULTU: unsigned WIDTH×WIDTH→2·WIDTH, giving {hi,lo}.
  - DIV: signed; lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - DIVU: unsigned; lo=quotient, hi=remainder.
  - Divide by zero (B==0): still busy for DIV_CYCLES, then HI/LO are left unchanged.
  - Signed overflow, A=−2^(WIDTH−1) with B=−1: lo=−2^(WIDTH−1), hi=0.
  - MADD: {hi,lo} ← {hi,lo} + signed(A×B), modulo 2^(2·WIDTH). The accumulator base is the HI/LO value at the `start` edge.
  - MSUB: {hi,lo} ← {hi,lo} − signed(A×B), same rules as MADD.
- `hi`/`lo` never show intermediate values. They change only at reset, on MTHI/MTLO, or at op completion.

## Timing
- For `start` sampled at edge t, `busy` is high from just after t until just after t+N, where N=MULT_CYCLES or DIV_CYCLES. That is N cycles of busy.
- The new HI/LO values are visible after edge t+N, the same edge at which `busy` falls.
- Back-to-back: a `start` in the cycle where `busy` has just fallen is accepted.
- MTHI/MTLO: the value is visible one edge after `start`, and `busy` stays 0.
- Reset mid-RUN: at the next edge with `reset==0`, the op is abandoned, `busy=0`, and `hi=lo=0`. No partial commit.
- `reset==0` together with `start==1`: reset wins and `start` is dropped.
- `busy`, `hi` and `lo` are registered outputs with no combinational path from the inputs.

## Configuration
- `MD_UNIT_MADD_EN`
  - Defined: op 110/111 perform MADD/MSUB with MULT_CYCLES latency.
  - Undefined: op 110/111 are treated as no-ops. No state change, no busy, HI/LO untouched. The accumulate adder is not synthesised.

## Test plan
- Reset with WIDTH=32: hold `reset=0` for 2 cycles → `busy=0`, `hi=0`, `lo=0`.
- Signed MULT and unsigned MULTU:
  - MULT A=0xFFFFFFFE(−2), B=3 → busy exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV A=−7, B=2 → busy exactly 10 cycles, then lo=0xFFFFFFFD(−3), hi=0xFFFFFFFF(−1). DIVU A=7, B=0 → after 10 cycles HI/LO hold their prior values.
- Control ops and interleaving:
  - MTHI A=0x12345678 → hi=0x12345678 next edge, busy never rises.
  - A `start` MTLO issued mid-DIV → ignored, and lo holds the div result after completion.
- Reset on the third cycle of a MULT → busy drops next edge, hi=lo=0, and no late commit occurs in later cycles.
- With `MD_UNIT_MADD_EN`:
  - hi:lo=0:0x10, MADD 3×4 → lo=0x1C after 5 cycles.
  - Then MSUB 1×0x1D → hi=lo=0xFFFFFFFF.
  - Without the macro, op 110 leaves lo=0x10 and busy=0.

Source files
------------

// File: rtl/md_unit_if.sv
// md_unit_if: operation/result bundle between the E stage and md_unit.
//   start  launch strobe for op
//   op     operation code (MULT, MULTU, DIV, DIVU, MTHI, MTLO, MADD, MSUB)
//   A, B   forwarded rs/rt operands
//   busy   an operation is in flight
//   hi, lo architectural HI/LO registers
// Modports: master drives the operation, slave (md_unit) returns busy/hi/lo.
interface md_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, A, B, input busy, hi, lo);
  modport slave  (input start, op, A, B, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO register pair.
// The result is computed when the op is accepted, held in a pending pair
// (tempHi/tempLo), and committed to HI/LO when the latency counter expires,
// so hi/lo never show intermediate values.
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous, active-low; clears all state
//   md     md_unit_if.slave: start/op/A/B in, busy/hi/lo out (all registered)
// Parameters: WIDTH, MULT_CYCLES (>=1), DIV_CYCLES (>=1).
// Optional feature: define MD_UNIT_MADD_EN to enable MADD/MSUB (ops 110/111);
// without it those ops are no-ops and the accumulate adder is not built.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  md_unit_if.slave  md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MADD  = 3'b110,
    OP_MSUB  = 3'b111
  } opT;

  typedef enum logic {IDLE, RUN} stateT;

  stateT            state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext, latency;
  logic             timedOp, mtHi, mtLo, launch, commit;
  logic [WIDTH-1:0] hiReg, loReg, tempHi, tempLo, resHi, resLo;

  // ---------------- arithmetic on the live operands ----------------
  logic [2*WIDTH-1:0]        prodS, prodU;
  logic                      divOverflow;
  logic [WIDTH-1:0]          divSafeS, divSafeU, quoU, remU;
  logic signed [WIDTH-1:0]   quoS, remS;

  // Sign-extending to 2*WIDTH first makes the low 2*WIDTH bits of the
  // unsigned product equal the signed product.
  assign prodS = {{WIDTH{md.A[WIDTH-1]}}, md.A} * {{WIDTH{md.B[WIDTH-1]}}, md.B};
  assign prodU = {{WIDTH{1'b0}}, md.A} * {{WIDTH{1'b0}}, md.B};

  // Divisor of 1 for B==0 (result discarded) and for MIN/-1: dividing MIN
  // by 1 yields exactly the required overflow result (lo=MIN, hi=0) while
  // keeping the divider away from the unrepresentable quotient.
  assign divOverflow = (md.A == MIN_NEG) && (md.B == {WIDTH{1'b1}});
  assign divSafeS    = (md.B == '0 || divOverflow) ? ONE : md.B;
  assign divSafeU    = (md.B == '0) ? ONE : md.B;
  assign quoS        = $signed(md.A) / $signed(divSafeS);
  assign remS        = $signed(md.A) % $signed(divSafeS);
  assign quoU        = md.A / divSafeU;
  assign remU        = md.A % divSafeU;

`ifdef MD_UNIT_MADD_EN
  logic [2*WIDTH-1:0] accAdd, accSub;
  // Base is HI/LO as seen at the start edge; the product wraps mod 2^(2W).
  assign accAdd = {hiReg, loReg} + prodS;
  assign accSub = {hiReg, loReg} - prodS;
`endif

  // ---------------- decode, result select, next state ----------------
  // NOTE: every signal written here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    latency   = CNT_W'(MULT_CYCLES);
    timedOp   = 1'b0;
    mtHi      = 1'b0;
    mtLo      = 1'b0;
    resHi     = hiReg;
    resLo     = loReg;
    stateNext = state;
    cntNext   = cnt;
    commit    = 1'b0;

    case (md.op)
      OP_MULT:  begin timedOp = 1'b1; {resHi, resLo} = prodS; end
      OP_MULTU: begin timedOp = 1'b1; {resHi, resLo} = prodU; end
      OP_DIV: begin
        timedOp = 1'b1;
        latency = CNT_W'(DIV_CYCLES);
        // Divide by zero keeps the current HI/LO as the pending result.
        if (md.B != '0) begin
          resHi = remS;
          resLo = quoS;
        end
      end
      OP_DIVU: begin
        timedOp = 1'b1;
        latency = CNT_W'(DIV_CYCLES);
        if (md.B != '0) begin
          resHi = remU;
          resLo = quoU;
        end
      end
      OP_MTHI: mtHi = 1'b1;
      OP_MTLO: mtLo = 1'b1;
`ifdef MD_UNIT_MADD_EN
      OP_MADD: begin timedOp = 1'b1; {resHi, resLo} = accAdd; end
      OP_MSUB: begin timedOp = 1'b1; {resHi, resLo} = accSub; end
`endif
      default: ;
    endcase

    case (state)
      IDLE: begin
        if (md.start && timedOp) begin
          stateNext = RUN;
          cntNext   = latency;
        end
      end
      RUN: begin
        cntNext = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          stateNext = IDLE;
          commit    = 1'b1;
        end
      end
    endcase
  end

  // start is only honoured in IDLE; anything arriving during RUN is dropped.
  assign launch = (state == IDLE) && md.start && timedOp;

  // ---------------- state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // ---------------- HI/LO and pending result ----------------
  // NOTE: the pending pair is reset along with HI/LO; it is only a couple of
  // registers, and a clean value keeps an abandoned op from ever resurfacing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hiReg  <= '0;
      loReg  <= '0;
      tempHi <= '0;
      tempLo <= '0;
    end else begin
      if (launch) begin
        tempHi <= resHi;
        tempLo <= resLo;
      end
      if (commit) begin
        hiReg <= tempHi;
        loReg <= tempLo;
      end
      if (state == IDLE && md.start && mtHi) hiReg <= md.A;
      if (state == IDLE && md.start && mtLo) loReg <= md.A;
    end
  end

  assign md.busy = (state == RUN);
  assign md.hi   = hiReg;
  assign md.lo   = loReg;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit (WIDTH=32,
// MULT_CYCLES=5, DIV_CYCLES=10). MADD/MSUB expectations follow
// MD_UNIT_MADD_EN.
module tb_md_unit;

  localparam int WIDTH = 32;

  localparam logic [2:0] MULT  = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b011;
  localparam logic [2:0] MTHI  = 3'b100;
  localparam logic [2:0] MTLO  = 3'b101;
  localparam logic [2:0] MADD  = 3'b110;
  localparam logic [2:0] MSUB  = 3'b111;

  logic clk = 1'b0;
  logic reset;
  int   nChecks = 0;
  int   nFail   = 0;

  always #5 clk = ~clk;

  md_unit_if #(.WIDTH(WIDTH)) md ();

  md_unit #(
    .WIDTH(WIDTH),
    .MULT_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .md(md.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one op at a negedge and counts busy cycles sampled on negedges.
  // Optionally injects a second start (injOp/injA) on busy cycle injectAt.
  // hiloMoved flags any hi/lo change while busy was high.
  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int injectAt, input logic [2:0] injOp, input logic [31:0] injA,
                       output int busyCycles, output bit hiloMoved);
    logic [31:0] hi0, lo0;
    bit done;
    hi0 = md.hi;
    lo0 = md.lo;
    md.start = 1'b1;
    md.op    = op;
    md.A     = a;
    md.B     = b;
    @(posedge clk);
    busyCycles = 0;
    hiloMoved  = 1'b0;
    done       = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      md.start = 1'b0;
      if (!md.busy) begin
        done = 1'b1;
      end else begin
        busyCycles++;
        if (md.hi !== hi0 || md.lo !== lo0) hiloMoved = 1'b1;
        if (busyCycles == injectAt) begin
          md.start = 1'b1;
          md.op    = injOp;
          md.A     = injA;
        end
      end
    end
    if (!done) check("busy_timeout", {63'd0, md.busy}, 64'd0);
  endtask

  int busyN;
  bit moved;

  initial begin
    md.start = 1'b0;
    md.op    = MULT;
    md.A     = '0;
    md.B     = '0;
    reset    = 1'b0;

    // Reset held 2 cycles, with a competing MTHI start that must be dropped.
    @(negedge clk);
    md.start = 1'b1; md.op = MTHI; md.A = 32'hA5A5_A5A5;
    repeat (2) @(negedge clk);
    check("reset_busy", {63'd0, md.busy}, 64'd0);
    check("reset_hi", md.hi, 64'h0);
    check("reset_lo", md.lo, 64'h0);
    md.start = 1'b0;
    reset    = 1'b1;
    @(negedge clk);

    // MULT -2*3
    runOp(MULT, 32'hFFFF_FFFE, 32'd3, 0, MULT, '0, busyN, moved);
    check("mult_busy", busyN, 5);
    check("mult_stable", {63'd0, moved}, 64'd0);
    check("mult_hi", md.hi, 64'hFFFF_FFFF);
    check("mult_lo", md.lo, 64'hFFFF_FFFA);

    // MULTU, same operands, issued back-to-back
    runOp(MULTU, 32'hFFFF_FFFE, 32'd3, 0, MULT, '0, busyN, moved);
    check("multu_busy", busyN, 5);
    check("multu_hi", md.hi, 64'h0000_0002);
    check("multu_lo", md.lo, 64'hFFFF_FFFA);

    // DIV -7/2
    runOp(DIV, 32'hFFFF_FFF9, 32'd2, 0, MULT, '0, busyN, moved);
    check("div_busy", busyN, 10);
    check("div_stable", {63'd0, moved}, 64'd0);
    check("div_lo", md.lo, 64'hFFFF_FFFD);
    check("div_hi", md.hi, 64'hFFFF_FFFF);

    // DIVU by zero: busy full latency, HI/LO unchanged
    runOp(DIVU, 32'd7, 32'd0, 0, MULT, '0, busyN, moved);
    check("divz_busy", busyN, 10);
    check("divz_hi", md.hi, 64'hFFFF_FFFF);
    check("divz_lo", md.lo, 64'hFFFF_FFFD);

    // DIVU 100/7
    runOp(DIVU, 32'd100, 32'd7, 0, MULT, '0, busyN, moved);
    check("divu_lo", md.lo, 64'h0000_000E);
    check("divu_hi", md.hi, 64'h0000_0002);

    // DIV 7/-2: remainder follows the dividend sign
    runOp(DIV, 32'd7, 32'hFFFF_FFFE, 0, MULT, '0, busyN, moved);
    check("divneg_lo", md.lo, 64'hFFFF_FFFD);
    check("divneg_hi", md.hi, 64'h0000_0001);

    // DIV overflow MIN / -1
    runOp(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, MULT, '0, busyN, moved);
    check("divovf_lo", md.lo, 64'h8000_0000);
    check("divovf_hi", md.hi, 64'h0000_0000);

    // MTHI: visible next edge, no busy
    runOp(MTHI, 32'h1234_5678, 32'd0, 0, MULT, '0, busyN, moved);
    check("mthi_busy", busyN, 0);
    check("mthi_hi", md.hi, 64'h1234_5678);
    check("mthi_lo_kept", md.lo, 64'h8000_0000);

    // MTLO issued mid-DIV is ignored
    runOp(DIV, 32'd20, 32'd3, 3, MTLO, 32'h0000_DEAD, busyN, moved);
    check("inj_busy", busyN, 10);
    check("inj_stable", {63'd0, moved}, 64'd0);
    check("inj_lo", md.lo, 64'h0000_0006);
    check("inj_hi", md.hi, 64'h0000_0002);

    // Reset on the third busy cycle of MULT 0x10000*0x10000 (result hi=1)
    md.start = 1'b1; md.op = MULT; md.A = 32'h0001_0000; md.B = 32'h0001_0000;
    @(posedge clk);
    repeat (3) @(negedge clk);
    md.start = 1'b0;
    check("rst_mid_was_busy", {63'd0, md.busy}, 64'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("rst_mid_busy", {63'd0, md.busy}, 64'd0);
    check("rst_mid_hi", md.hi, 64'h0);
    check("rst_mid_lo", md.lo, 64'h0);
    repeat (12) @(negedge clk);
    check("rst_late_hi", md.hi, 64'h0);
    check("rst_late_lo", md.lo, 64'h0);
    check("rst_late_busy", {63'd0, md.busy}, 64'd0);

    // Accumulate ops with hi:lo = 0:0x10
    runOp(MTLO, 32'h0000_0010, 32'd0, 0, MULT, '0, busyN, moved);
    check("mtlo_lo", md.lo, 64'h0000_0010);
`ifdef MD_UNIT_MADD_EN
    runOp(MADD, 32'd3, 32'd4, 0, MULT, '0, busyN, moved);
    check("madd_busy", busyN, 5);
    check("madd_lo", md.lo, 64'h0000_001C);
    check("madd_hi", md.hi, 64'h0000_0000);
    runOp(MSUB, 32'd1, 32'h0000_001D, 0, MULT, '0, busyN, moved);
    check("msub_busy", busyN, 5);
    check("msub_lo", md.lo, 64'hFFFF_FFFF);
    check("msub_hi", md.hi, 64'hFFFF_FFFF);
`else
    runOp(MADD, 32'd3, 32'd4, 0, MULT, '0, busyN, moved);
    check("madd_off_busy", busyN, 0);
    check("madd_off_lo", md.lo, 64'h0000_0010);
    check("madd_off_hi", md.hi, 64'h0000_0000);
    runOp(MSUB, 32'd1, 32'h0000_001D, 0, MULT, '0, busyN, moved);
    check("msub_off_busy", busyN, 0);
    check("msub_off_lo", md.lo, 64'h0000_0010);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
